// File: rtl/fbp_norm_pipe.sv
// fbp_norm_pipe: handshaked first-bit-position normaliser.
// Mode 0 locates the leading one and shifts it up to the MSB.
// Mode 1 locates the trailing one and shifts it down to bit 0.
// The default build is two stages (operand register A, result register B).
// Build option FBP_NORM_LAT1_EN removes stage A, so the result registers
// load straight from the input port.
module fbp_norm_pipe #(
    parameter  int WIDTH = 32,
    localparam int PW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_pos,
    output logic [PW-1:0]    out_shamt,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_zero,
    output logic             out_mode
);

    // The search runs over a window padded with zeros up to the next power of two.
    localparam int NP = 1 << PW;

    logic [WIDTH-1:0] src_value;
    logic             src_mode;
    logic             b_load;

    logic             b_v_q, b_v_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [PW-1:0]    shamt_q, shamt_d;
    logic [WIDTH-1:0] norm_q, norm_d;
    logic             zero_q, zero_d;
    logic             mode_q, mode_d;

    logic [PW-1:0]    srch_pos;
    logic [PW-1:0]    srch_shamt;
    logic [WIDTH-1:0] srch_norm;
    logic             srch_zero;
    logic [NP-1:0]    win;
    logic [NP-1:0]    mask;
    int               cnt;

`ifndef FBP_NORM_LAT1_EN
    logic             a_v_q, a_v_d;
    logic [WIDTH-1:0] a_value_q, a_value_d;
    logic             a_mode_q, a_mode_d;
    logic             a_load;

    assign b_load    = a_v_q && (!b_v_q || out_ready);
    assign in_ready  = !a_v_q || b_load;
    assign a_load    = in_valid && in_ready;
    assign src_value = a_value_q;
    assign src_mode  = a_mode_q;

    // Stage A: capture the operand on an input transfer, empty when B takes it.
    always_comb begin
        a_v_d     = a_v_q;
        a_value_d = a_value_q;
        a_mode_d  = a_mode_q;
        if (a_load) begin
            a_v_d     = 1'b1;
            a_value_d = in_value;
            a_mode_d  = in_mode;
        end else if (b_load) begin
            a_v_d = 1'b0;
        end
    end

    // Stage A registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v_q     <= 1'b0;
            a_value_q <= '0;
            a_mode_q  <= 1'b0;
        end else begin
            a_v_q     <= a_v_d;
            a_value_q <= a_value_d;
            a_mode_q  <= a_mode_d;
        end
    end
`else
    assign in_ready  = !b_v_q || out_ready;
    assign b_load    = in_valid && in_ready;
    assign src_value = in_value;
    assign src_mode  = in_mode;
`endif

    // Log2 search: each level tests the outer half of the remaining window
    // and shifts it away when empty, accumulating the zero count. The shifted
    // window is the normalised operand.
    always_comb begin
        win  = NP'(src_value);
        mask = '0;
        cnt  = 0;
        for (int l = PW - 1; l >= 0; l--) begin
            if (!src_mode) begin
                mask = {NP{1'b1}} << (NP - (1 << l));
                if ((win & mask) == '0) begin
                    win = win << (1 << l);
                    cnt = cnt + (1 << l);
                end
            end else begin
                mask = {NP{1'b1}} >> (NP - (1 << l));
                if ((win & mask) == '0) begin
                    win = win >> (1 << l);
                    cnt = cnt + (1 << l);
                end
            end
        end
        srch_zero  = (src_value == '0);
        srch_pos   = '0;
        srch_shamt = '0;
        srch_norm  = '0;
        if (!srch_zero) begin
            if (!src_mode) begin
                srch_pos   = PW'(NP - 1 - cnt);
                srch_shamt = PW'(WIDTH - NP + cnt);
                srch_norm  = win[NP-1 -: WIDTH];
            end else begin
                srch_pos   = PW'(cnt);
                srch_shamt = PW'(cnt);
                srch_norm  = win[WIDTH-1:0];
            end
        end
    end

    // Stage B: load the search result when A (or the input) hands over,
    // otherwise hold until the consumer takes it.
    always_comb begin
        b_v_d   = b_v_q;
        pos_d   = pos_q;
        shamt_d = shamt_q;
        norm_d  = norm_q;
        zero_d  = zero_q;
        mode_d  = mode_q;
        if (b_load) begin
            b_v_d   = 1'b1;
            pos_d   = srch_pos;
            shamt_d = srch_shamt;
            norm_d  = srch_norm;
            zero_d  = srch_zero;
            mode_d  = src_mode;
        end else if (out_ready) begin
            b_v_d = 1'b0;
        end
    end

    // Stage B registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_v_q   <= 1'b0;
            pos_q   <= '0;
            shamt_q <= '0;
            norm_q  <= '0;
            zero_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            b_v_q   <= b_v_d;
            pos_q   <= pos_d;
            shamt_q <= shamt_d;
            norm_q  <= norm_d;
            zero_q  <= zero_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = b_v_q;
    assign out_pos   = pos_q;
    assign out_shamt = shamt_q;
    assign out_norm  = norm_q;
    assign out_zero  = zero_q;
    assign out_mode  = mode_q;

endmodule

// File: tb/tb_fbp_norm_pipe.sv
// Bench for fbp_norm_pipe: a 32-bit instance under directed and random
// traffic against a scoreboard, plus a 24-bit instance under directed cases.
module tb_fbp_norm_pipe;

`ifdef FBP_NORM_LAT1_EN
    localparam int LAT   = 1;
    localparam int DEPTH = 1;
`else
    localparam int LAT   = 2;
    localparam int DEPTH = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_mode;
    logic [31:0] in_value;
    logic        out_valid, out_ready, out_zero, out_mode;
    logic [4:0]  out_pos, out_shamt;
    logic [31:0] out_norm;

    logic        t_in_valid, t_in_ready, t_in_mode;
    logic [23:0] t_in_value;
    logic        t_out_valid, t_out_ready, t_out_zero, t_out_mode;
    logic [4:0]  t_out_pos, t_out_shamt;
    logic [23:0] t_out_norm;

    fbp_norm_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
        .out_shamt(out_shamt), .out_norm(out_norm), .out_zero(out_zero), .out_mode(out_mode)
    );

    fbp_norm_pipe #(.WIDTH(24)) dut24 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_in_valid), .in_ready(t_in_ready), .in_value(t_in_value), .in_mode(t_in_mode),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .out_pos(t_out_pos),
        .out_shamt(t_out_shamt), .out_norm(t_out_norm), .out_zero(t_out_zero), .out_mode(t_out_mode)
    );

    typedef struct {
        logic [63:0] pos;
        logic [63:0] shamt;
        logic [63:0] norm;
        logic [63:0] zero;
        logic [63:0] mode;
    } exp_t;

    exp_t q32[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pops     = 0;
    bit   saw_block = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: scan bits for highest/lowest one, then shift with plain operators.
    function automatic void ref_model(input int w, input logic [63:0] v_in, input logic m,
                                      output logic [63:0] pos, output logic [63:0] shamt,
                                      output logic [63:0] norm, output logic [63:0] zero);
        logic [63:0] msk;
        logic [63:0] v;
        int p;
        msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        v = v_in & msk;
        p = 0;
        pos = 0; shamt = 0; norm = 0; zero = 0;
        if (v == 0) begin
            zero = 1;
        end else if (!m) begin
            for (int i = 0; i < w; i++) if (v[i]) p = i;
            pos   = 64'(p);
            shamt = 64'(w - 1 - p);
            norm  = (v << (w - 1 - p)) & msk;
        end else begin
            for (int i = w - 1; i >= 0; i--) if (v[i]) p = i;
            pos   = 64'(p);
            shamt = 64'(p);
            norm  = v >> p;
        end
    endfunction

    // Scoreboard for the 32-bit instance: every valid output must match the
    // oldest outstanding operand, which is retired on an output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (q32.size() == 0) begin
                    chk("out_spurious", 64'(out_valid), 64'd0);
                end else begin
                    chk("sb_pos",   64'(out_pos),   q32[0].pos);
                    chk("sb_shamt", 64'(out_shamt), q32[0].shamt);
                    chk("sb_norm",  64'(out_norm),  q32[0].norm);
                    chk("sb_zero",  64'(out_zero),  q32[0].zero);
                    chk("sb_mode",  64'(out_mode),  q32[0].mode);
                    if (out_ready) begin
                        q32.delete(0);
                        pops++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                ref_model(32, 64'(in_value), in_mode, e.pos, e.shamt, e.norm, e.zero);
                e.mode = 64'(in_mode);
                q32.push_back(e);
            end
        end
    end

    task automatic send32(input logic [31:0] v, input logic m);
        int n = 0;
        in_valid = 1'b1;
        in_value = v;
        in_mode  = m;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            saw_block = 1;
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send32_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // One operand into an empty pipe with out_ready high; checks latency and result.
    task automatic single32(input logic [31:0] v, input logic m, input int ep, input int es,
                            input logic [31:0] en, input logic ez);
        int n = 0;
        in_valid = 1'b1; in_value = v; in_mode = m;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 10);
        chk("lat32",   64'(n),         64'(LAT));
        chk("d_pos",   64'(out_pos),   64'(ep));
        chk("d_shamt", 64'(out_shamt), 64'(es));
        chk("d_norm",  64'(out_norm),  64'(en));
        chk("d_zero",  64'(out_zero),  64'(ez));
        chk("d_mode",  64'(out_mode),  64'(m));
        @(posedge clk); #1;
    endtask

    task automatic single24(input logic [23:0] v, input logic m, input int ep, input int es,
                            input logic [23:0] en, input logic ez);
        int n = 0;
        t_in_valid = 1'b1; t_in_value = v; t_in_mode = m;
        do begin
            @(posedge clk); #1;
            t_in_valid = 1'b0;
            n++;
        end while (!t_out_valid && n < 10);
        chk("lat24",     64'(n),           64'(LAT));
        chk("w24_pos",   64'(t_out_pos),   64'(ep));
        chk("w24_shamt", 64'(t_out_shamt), 64'(es));
        chk("w24_norm",  64'(t_out_norm),  64'(en));
        chk("w24_zero",  64'(t_out_zero),  64'(ez));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1, 2: return 32'd1 << $urandom_range(0, 31);
            3: return 32'hFFFF_FFFF;
            4: return r << $urandom_range(0, 31);
            default: return r >> $urandom_range(0, 31);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        logic [63:0] ep, es, en, ez;
        logic [23:0] tv;
        logic        tm;

        rst_n = 1'b0;
        in_valid = 0; in_value = 0; in_mode = 0; out_ready = 0;
        t_in_valid = 0; t_in_value = 0; t_in_mode = 0; t_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready",  64'(in_ready),  1);
        chk("rst_pos",       64'(out_pos),   0);
        chk("rst_norm",      64'(out_norm),  0);
        chk("rst_zero",      64'(out_zero),  0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        single32(32'h0001_0000, 1'b0, 16, 15, 32'h8000_0000, 1'b0);
        single32(32'h0000_0A00, 1'b1, 9, 9, 32'h0000_0005, 1'b0);
        single32(32'hFFFF_FFFF, 1'b0, 31, 0, 32'hFFFF_FFFF, 1'b0);
        single32(32'hFFFF_FFFF, 1'b1, 0, 0, 32'hFFFF_FFFF, 1'b0);
        single32(32'h0000_0000, 1'b0, 0, 0, 32'h0, 1'b1);
        single32(32'h0000_0000, 1'b1, 0, 0, 32'h0, 1'b1);
        single32(32'h8000_0000, 1'b1, 31, 31, 32'h1, 1'b0);

        // Back-to-back stream with a 3-cycle consumer stall after the first result.
        p0 = pops;
        saw_block = 0;
        fork
            begin
                send32(32'h1, 1'b0);
                send32(32'h2, 1'b0);
                send32(32'h4, 1'b0);
                send32(32'h8, 1'b0);
            end
            begin
                n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        n = 0;
        while ((pops - p0) < 4 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stream_count", 64'(pops - p0), 64'd4);
        chk("stream_backpressure", 64'(saw_block), 64'd1);

        // Random traffic with random consumer stalls.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_value  = rand_operand();
            in_mode   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q32.size() != 0 || out_valid) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(q32.size()), 64'd0);

        // Fill the pipe, then reset asynchronously mid-cycle.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send32(32'h1234_5678 + 32'(i), 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        #3 rst_n = 1'b0;
        q32.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_in_ready",  64'(in_ready),  1);
        chk("arst_pos",       64'(out_pos),   0);
        chk("arst_shamt",     64'(out_shamt), 0);
        chk("arst_norm",      64'(out_norm),  0);
        chk("arst_zero",      64'(out_zero),  0);
        chk("arst_mode",      64'(out_mode),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 0);
        end
        chk("post_rst_in_ready", 64'(in_ready), 1);
        @(posedge clk); #1;

        // Non-power-of-two width.
        single24(24'h80_0000, 1'b0, 23, 0, 24'h80_0000, 1'b0);
        single24(24'h00_0001, 1'b0, 0, 23, 24'h80_0000, 1'b0);
        single24(24'h00_0000, 1'b1, 0, 0, 24'h0, 1'b1);
        single24(24'h00_0600, 1'b1, 9, 9, 24'h3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tv = 24'($urandom) >> $urandom_range(0, 23);
            tm = 1'($urandom_range(0, 1));
            ref_model(24, 64'(tv), tm, ep, es, en, ez);
            single24(tv, tm, int'(ep), int'(es), en[23:0], ez[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
